// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port unified instruction/data memory of the multi-cycle
// MIPS between the core memory interface and a program/debug loader port.
// Each access walks IDLE -> ACCESS -> RESP, so one access completes every
// three cycles. The ack pulse doubles as the core controller's memory-wait
// release.
//
// Build option:
//   ARB_RR_EN  defined   : round-robin on ties (the port that did not own the
//                          last completed access wins)
//              undefined : fixed priority, core wins every tie
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata core request, held stable until c_ack
//   c_rdata, c_ack            core read data (bypassed during ack), 1-cycle ack
//   l_req/l_we/l_addr/l_wdata loader request, held stable until l_ack
//   l_rdata, l_ack            loader read data (bypassed during ack), 1-cycle ack
//   m_en/m_we/m_addr/m_wdata  registered controls to the synchronous memory
//   m_rdata                   memory read data, valid one cycle after m_en
//   gnt                       owner: 01 core, 10 loader, 00 none
//   busy                      high while in ACCESS or RESP
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_ack,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic [DATA_W-1:0] l_rdata,
   output logic              l_ack,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   output logic [1:0]        gnt,
   output logic              busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]        state;
   logic              op_we;       // direction of the access in flight
   logic [DATA_W-1:0] c_rdata_q;
   logic [DATA_W-1:0] l_rdata_q;
   logic              pick_loader; // IDLE-cycle winner: 1 loader, 0 core

`ifdef ARB_RR_EN
   logic last_loader;             // owner of the last completed access

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      pick_loader = l_req;
      if (c_req && l_req)
         pick_loader = !last_loader;
   end
`else
   always_comb begin
      pick_loader = l_req && !c_req;
   end
`endif

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous; a write presented in ACCESS still reaches
      // the memory at the same edge, only the arbiter's own state is cleared.
      if (rst) begin
         state     <= IDLE;
         op_we     <= 1'b0;
         m_en      <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         gnt       <= 2'b00;
         busy      <= 1'b0;
         c_ack     <= 1'b0;
         l_ack     <= 1'b0;
         c_rdata_q <= '0;
         l_rdata_q <= '0;
`ifdef ARB_RR_EN
         last_loader <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (c_req || l_req) begin
                  state <= ACCESS;
                  m_en  <= 1'b1;
                  busy  <= 1'b1;
                  if (pick_loader) begin
                     gnt     <= 2'b10;
                     m_we    <= l_we;
                     op_we   <= l_we;
                     m_addr  <= l_addr;
                     m_wdata <= l_wdata;
                  end else begin
                     gnt     <= 2'b01;
                     m_we    <= c_we;
                     op_we   <= c_we;
                     m_addr  <= c_addr;
                     m_wdata <= c_wdata;
                  end
               end
            end

            ACCESS: begin
               // Memory sees m_en for exactly this one cycle; the ack is
               // raised so it lines up with the read data of the next cycle.
               state <= RESP;
               m_en  <= 1'b0;
               m_we  <= 1'b0;
               c_ack <= gnt[0];
               l_ack <= gnt[1];
            end

            RESP: begin
               state <= IDLE;
               c_ack <= 1'b0;
               l_ack <= 1'b0;
               gnt   <= 2'b00;
               busy  <= 1'b0;
               if (!op_we) begin
                  if (gnt[0]) c_rdata_q <= m_rdata;
                  if (gnt[1]) l_rdata_q <= m_rdata;
               end
`ifdef ARB_RR_EN
               last_loader <= gnt[1];
`endif
            end

            default: begin
               state <= IDLE;
               m_en  <= 1'b0;
               m_we  <= 1'b0;
               gnt   <= 2'b00;
               busy  <= 1'b0;
               c_ack <= 1'b0;
               l_ack <= 1'b0;
            end
         endcase
      end
   end

   // Memory read data arrives in the ack cycle; forward it straight through
   // so the requester can use it then, and hold the captured copy afterwards.
   assign c_rdata = (c_ack && !op_we) ? m_rdata : c_rdata_q;
   assign l_rdata = (l_ack && !op_we) ? m_rdata : l_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A behavioural synchronous memory sits
// on the m_* port. Expected transactions are queued when stimulus is driven
// and compared in order against completed acks. Inputs change and outputs are
// sampled on the falling clock edge. Honours ARB_RR_EN like the design.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          c_req, c_we, l_req, l_we;
   logic [AW-1:0] c_addr, l_addr, m_addr;
   logic [DW-1:0] c_wdata, l_wdata, c_rdata, l_rdata, m_wdata, m_rdata;
   logic          c_ack, l_ack, m_en, m_we, busy;
   logic [1:0]    gnt;
   logic          mem_init;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          port;   // 0 core, 1 loader
      bit          we;
      logic [1:0]  gnt;
      logic [31:0] addr;
      logic [31:0] data;   // write data, or expected read data
   } exp_t;

   typedef struct {
      bit          port;
      bit          we;
      logic [1:0]  gnt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          en_cyc;
      int          ack_cyc;
   } obs_t;

   exp_t exp_q[$];
   obs_t obs_q[$];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ack(c_ack),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_rdata(l_rdata), .l_ack(l_ack),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .gnt(gnt), .busy(busy)
   );

   // Synchronous single-port memory, word addressed by m_addr[7:2].
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[4]  <= 32'hDEADBEEF;   // byte address 0x10
         m_rdata <= 32'h0;
      end else if (m_en) begin
         if (m_we) mem[m_addr[7:2]] <= m_wdata;
         m_rdata <= mem[m_addr[7:2]];
      end
   end

   function automatic logic [67:0] key(bit port, bit we, logic [1:0] g,
                                       logic [31:0] a, logic [31:0] d);
      return {port, we, g, a, d};
   endfunction

   // Collect n acks within a cycle budget; optionally drop a port's request
   // in its ack cycle. Cycle numbers count falling edges from the call.
   task automatic observe(input int n, input int budget,
                          input bit drop_c, input bit drop_l);
      int got = 0;
      int k = 0;
      bit we_s = 1'b0;
      logic [31:0] wd_s = '0;
      int en_s = -1;
      obs_t o;
      while (got < n && k < budget) begin
         @(negedge clk);
         k++;
         if (m_en) begin
            we_s = m_we; wd_s = m_wdata; en_s = k;
         end
         if (c_ack || l_ack) begin
            o.port = l_ack; o.we = we_s; o.gnt = gnt; o.addr = m_addr;
            o.wdata = wd_s; o.rdata = l_ack ? l_rdata : c_rdata;
            o.en_cyc = en_s; o.ack_cyc = k;
            obs_q.push_back(o);
            got++;
            if (c_ack && drop_c) c_req = 1'b0;
            if (l_ack && drop_l) l_req = 1'b0;
         end
      end
      if (got < n) begin
         checks++; failures++;
         $display("FAIL ack_timeout: got %0d acks, required %0d within %0d cycles", got, n, budget);
      end
   endtask

   task automatic push_exp(input bit port, input bit we, input logic [31:0] a,
                           input logic [31:0] d);
      exp_t e;
      e.port = port; e.we = we; e.gnt = port ? 2'b10 : 2'b01; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({c_ack, l_ack, m_en, m_we, busy, gnt} !== 7'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b required 0000000", {c_ack, l_ack, m_en, m_we, busy, gnt});
      end
      checks++;
      if ({c_rdata, l_rdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_rdata: got %h required 0", {c_rdata, l_rdata});
      end
      checks++;
      if ({m_addr, m_wdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_mbus: got %h required 0", {m_addr, m_wdata});
      end
      rst = 1'b0;
   endtask

   task automatic test_core_read();
      obs_t o; exp_t e;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      push_exp(1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
      observe(1, 10, 1'b1, 1'b1);
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (key(o.port, o.we, o.gnt, o.addr, o.rdata) !== key(e.port, e.we, e.gnt, e.addr, e.data)) begin
            failures++;
            $display("FAIL core_read_txn: got %h required %h", key(o.port, o.we, o.gnt, o.addr, o.rdata), key(e.port, e.we, e.gnt, e.addr, e.data));
         end
         checks++;
         if ({o.en_cyc, o.ack_cyc} !== {32'sd1, 32'sd2}) begin
            failures++;
            $display("FAIL core_read_latency: got m_en=%0d ack=%0d required 1 2", o.en_cyc, o.ack_cyc);
         end
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      checks++;
      if (c_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL core_rdata_hold: got %h required deadbeef", c_rdata);
      end
   endtask

   task automatic test_loader_write();
      obs_t o; exp_t e;
      @(negedge clk);
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'h20; l_wdata = 32'h12345678;
      push_exp(1'b1, 1'b1, 32'h20, 32'h12345678);
      observe(1, 10, 1'b1, 1'b1);
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (key(o.port, o.we, o.gnt, o.addr, o.wdata) !== key(e.port, e.we, e.gnt, e.addr, e.data)) begin
            failures++;
            $display("FAIL loader_write_txn: got %h required %h", key(o.port, o.we, o.gnt, o.addr, o.wdata), key(e.port, e.we, e.gnt, e.addr, e.data));
         end
         checks++;
         if ({o.en_cyc, o.ack_cyc} !== {32'sd1, 32'sd2}) begin
            failures++;
            $display("FAIL loader_write_latency: got m_en=%0d ack=%0d required 1 2", o.en_cyc, o.ack_cyc);
         end
         checks++;
         if (o.rdata !== 32'h0) begin
            failures++;
            $display("FAIL loader_write_rdata: got %h required 0", o.rdata);
         end
      end
      exp_q.delete();
      @(negedge clk);
      checks++;
      if ({l_rdata, mem[8]} !== {32'h0, 32'h12345678}) begin
         failures++;
         $display("FAIL loader_write_mem: got l_rdata=%h mem=%h required 0 12345678", l_rdata, mem[8]);
      end
   endtask

   task automatic test_tie();
      obs_t o; exp_t e;
      int idx;
      // Three ties: the first two go to the core in either mode; the third
      // follows a core-only access, so round-robin hands it to the loader.
      for (int t = 0; t < 3; t++) begin
         if (t == 2) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
            push_exp(1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
            observe(1, 10, 1'b1, 1'b1);
         end
         @(negedge clk);
         c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
         l_req = 1'b1; l_we = 1'b0; l_addr = 32'h10;
`ifdef ARB_RR_EN
         if (t == 2) begin
            push_exp(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
            push_exp(1'b0, 1'b0, 32'h20, 32'h12345678);
         end else begin
            push_exp(1'b0, 1'b0, 32'h20, 32'h12345678);
            push_exp(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
         end
`else
         push_exp(1'b0, 1'b0, 32'h20, 32'h12345678);
         push_exp(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
`endif
         observe(2, 20, 1'b1, 1'b1);
         idx = 0;
         while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (key(o.port, o.we, o.gnt, o.addr, o.rdata) !== key(e.port, e.we, e.gnt, e.addr, e.data)) begin
               failures++;
               $display("FAIL tie%0d_txn: got %h required %h", t, key(o.port, o.we, o.gnt, o.addr, o.rdata), key(e.port, e.we, e.gnt, e.addr, e.data));
            end
            // The pre-tie core access is acked at cycle 2 of its own observe.
            if (!(t == 2 && idx == 0 && o.ack_cyc == 2 && obs_q.size() == 2)) begin
               checks++;
               if (o.ack_cyc !== ((obs_q.size() == 0) ? 5 : 2)) begin
                  failures++;
                  $display("FAIL tie%0d_ack_cycle: got %0d required %0d", t, o.ack_cyc, (obs_q.size() == 0) ? 5 : 2);
               end
            end
            idx++;
         end
         exp_q.delete();
      end
   endtask

   task automatic test_starvation();
      int c_cnt = 0;
      int l_cnt = 0;
      int first_l = -1;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (c_ack) c_cnt++;
         if (l_ack) begin
            l_cnt++;
            if (first_l < 0) first_l = k;
         end
      end
      c_req = 1'b0; l_req = 1'b0;
      repeat (4) @(negedge clk);
`ifdef ARB_RR_EN
      checks++;
      if (first_l < 1 || first_l > 6) begin
         failures++;
         $display("FAIL rr_no_starve: first l_ack at %0d required 1..6", first_l);
      end
      checks++;
      if (c_cnt + l_cnt !== 10) begin
         failures++;
         $display("FAIL rr_throughput: got %0d acks required 10", c_cnt + l_cnt);
      end
`else
      checks++;
      if (l_cnt !== 0) begin
         failures++;
         $display("FAIL fixed_starve: got %0d loader acks required 0", l_cnt);
      end
      checks++;
      if (c_cnt !== 10) begin
         failures++;
         $display("FAIL fixed_throughput: got %0d core acks required 10", c_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      obs_t o; exp_t e;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      checks++;
      if ({m_en, m_we, m_addr} !== {2'b11, 32'h30}) begin
         failures++;
         $display("FAIL rst_access_bus: got en=%b we=%b addr=%h required 1 1 30", m_en, m_we, m_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({c_ack, l_ack, m_en, m_we, busy, gnt, m_addr, m_wdata} !== 71'h0) begin
         failures++;
         $display("FAIL rst_access_outputs: got %h required 0", {c_ack, l_ack, m_en, m_we, busy, gnt, m_addr, m_wdata});
      end
      checks++;
      if (mem[12] !== 32'hA5A5A5A5) begin
         failures++;
         $display("FAIL rst_access_mem_write: got %h required a5a5a5a5", mem[12]);
      end
      rst = 1'b0;
      c_wdata = 32'h5A5A5A5A;  // reissued request carries new data
      push_exp(1'b0, 1'b1, 32'h30, 32'h5A5A5A5A);
      observe(1, 10, 1'b1, 1'b1);
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++;
         if (key(o.port, o.we, o.gnt, o.addr, o.wdata) !== key(e.port, e.we, e.gnt, e.addr, e.data)) begin
            failures++;
            $display("FAIL reissue_txn: got %h required %h", key(o.port, o.we, o.gnt, o.addr, o.wdata), key(e.port, e.we, e.gnt, e.addr, e.data));
         end
         checks++;
         if (o.ack_cyc !== 2) begin
            failures++;
            $display("FAIL reissue_latency: got %0d required 2", o.ack_cyc);
         end
      end
      exp_q.delete();
      // Reset during RESP of a read: no capture into the rdata register.
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      repeat (2) @(negedge clk);
      checks++;
      if ({c_ack, c_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL resp_bypass: got ack=%b rdata=%h required 1 deadbeef", c_ack, c_rdata);
      end
      rst = 1'b1; c_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({c_ack, c_rdata} !== 33'h0) begin
         failures++;
         $display("FAIL rst_resp_capture: got ack=%b rdata=%h required 0 0", c_ack, c_rdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_late_request();
      exp_t e;
      int l_en = -1;
      int l_ak = -1;
      logic [31:0] got;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h30;
      push_exp(1'b0, 1'b0, 32'h30, 32'h5A5A5A5A);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (m_en && k > 2 && l_en < 0) l_en = k;
         if ((c_ack || l_ack) && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = l_ack ? l_rdata : c_rdata;
            checks++;
            if (key(l_ack, 1'b0, gnt, m_addr, got) !== key(e.port, e.we, e.gnt, e.addr, e.data)) begin
               failures++;
               $display("FAIL late_txn: got %h required %h", key(l_ack, 1'b0, gnt, m_addr, got), key(e.port, e.we, e.gnt, e.addr, e.data));
            end
            if (c_ack) c_req = 1'b0;
            if (l_ack) begin l_req = 1'b0; l_ak = k; end
         end
         if (k == 2) begin
            l_req = 1'b1; l_we = 1'b0; l_addr = 32'h20;
            push_exp(1'b1, 1'b0, 32'h20, 32'h12345678);
         end
      end
      checks++;
      if ({l_en, l_ak} !== {32'sd4, 32'sd5} || exp_q.size() != 0) begin
         failures++;
         $display("FAIL late_timing: got m_en=%0d ack=%0d pending=%0d required 4 5 0", l_en, l_ak, exp_q.size());
      end
      exp_q.delete();
      checks++;
      if ({c_rdata, l_rdata} !== {32'h5A5A5A5A, 32'h12345678}) begin
         failures++;
         $display("FAIL late_rdata_hold: got %h required 5a5a5a5a12345678", {c_rdata, l_rdata});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; mem_init = 1'b1;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      repeat (2) @(negedge clk);
      mem_init = 1'b0;
      test_reset();
      test_core_read();
      test_loader_write();
      test_tie();
      test_starvation();
      test_reset_mid();
      test_late_request();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port unified instruction/data memory of the multi-cycle MIPS between the core's memory interface and a program/debug loader port. It serialises accesses through a three-state FSM, drives the memory with registered controls, returns read data, and signals completion with a one-cycle acknowledge that the core's controller uses as its memory-wait condition. It sits between the datapath's memory address/data mux and the memory array.

## Interface
- ADDR_W, 32, byte address width on all ports
- DATA_W, 32, data width on all ports
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  core request; held high until c_ack
- c_we  in  1  core write enable (1 = write, 0 = read)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_rdata  out  DATA_W  core read data, valid in c_ack cycle, held until next core read ack
- c_ack  out  1  one-cycle completion pulse to core
- l_req, l_we, l_addr, l_wdata, l_rdata, l_ack  same directions/widths/meaning for loader port
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid one cycle after m_en (synchronous read)
- gnt  out  2  current owner: 2'b01 core, 2'b10 loader, 2'b00 none
- busy  out  1  high in ACCESS and RESP

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req high, select winner, latch its we/addr/wdata into memory output registers, set gnt, go ACCESS; else stay.
- ACCESS: m_en=1, m_we=latched we for exactly this cycle; go RESP.
- RESP: m_en=m_we=0; winner's ack=1; on read, m_rdata captured into winner's rdata register at end of this cycle (rdata output value equals m_rdata during ack cycle via bypass mux); writes leave rdata unchanged; go IDLE, gnt cleared.
- Requester holds req and payload stable until ack; req still high in the cycle after ack is a new request.
- Requests arriving in ACCESS/RESP wait; never dropped.
- Arbitration on simultaneous requests per Configuration; single request always wins immediately.
- Loser's ack stays 0; loser is served in the next IDLE.

## Timing
- Reset values: state IDLE, c_ack=l_ack=0, c_rdata=l_rdata=0, m_en=m_we=0, m_addr=m_wdata=0, gnt=0, busy=0, last-owner=loader.
- Latency: req high in IDLE cycle N -> m_en cycle N+1 -> ack cycle N+2.
- Throughput: one access per 3 cycles; back-to-back from alternating owners with no idle gap beyond IDLE.
- Reset mid-operation: rst in ACCESS still lets memory sample that cycle's write at the same edge; no ack issued; requester must reissue. rst in RESP suppresses capture into rdata registers.
- All outputs registered except rdata bypass during ack.

## Configuration
- ARB_RR_EN defined: round-robin; on simultaneous requests the port that did not own the last completed access wins; last-owner updates in RESP.
- ARB_RR_EN undefined: fixed priority, core always wins ties; loader can starve under continuous core requests. last-owner register removed.

## Test plan
- Reset then core read, addr 0x10, m_rdata 0xDEADBEEF -> m_en cycle 1, c_ack cycle 2, c_rdata=0xDEADBEEF held after.
- Loader write addr 0x20 data 0x12345678 -> m_en=m_we=1 in ACCESS with those values, l_ack 2 cycles after req, l_rdata unchanged (0).
- Simultaneous c_req/l_req after reset, both held -> core served first (gnt 01), loader second (gnt 10); with ARB_RR_EN next tie goes to core again, without it core every tie.
- Continuous core req, loader held, ARB_RR_EN undefined -> l_ack never asserts over 30 cycles; defined -> l_ack within 6 cycles.
- rst asserted during ACCESS of core write -> no c_ack, state IDLE, all outputs reset next cycle; reissued request completes normally.
- Request raised during RESP of other port -> not dropped, m_en exactly 2 cycles after RESP, ack 3 cycles after RESP.
